// File: rtl/oser10_pkg.sv
// Shared definitions for the OSER10 transmit lane: slot-clock constants,
// the lane state encoding and a helper for sizing the slot counter.
package oser10_pkg;

  localparam int unsigned PHASES = 5;
  localparam int unsigned WORD_W = 10;
  localparam logic [WORD_W-1:0] IDLE_WORD_DEF = 10'h2AA;

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_WARMUP = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_OFF    = 3'd4
  } state_e;

  // Width needed to hold the largest of the slot counts (at least 1 bit).
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/oser10_pclk_div.sv
// FCLK/5 phase counter with a registered 40%-duty PCLK and the load strobe
// marking the FCLK edge on which a new word is presented to the serializer.
module oser10_pclk_div
  import oser10_pkg::*;
#(
  parameter int unsigned LOAD_PHASE = 3
) (
  input  logic clk,
  input  logic rst_i,
  output logic pclk_o,
  output logic load_edge_o
);

  logic [2:0] phase_q, phase_d;
  logic       pclk_q;

  always_comb begin
    phase_d = (phase_q == 3'(PHASES - 1)) ? '0 : phase_q + 3'd1;
  end

  // PCLK is registered from the next phase so it is high exactly while the
  // phase register reads 0 or 1; reset parks the phase at 4 so the first
  // edge after release is a rising PCLK edge.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      phase_q <= 3'd4;
      pclk_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      pclk_q  <= (phase_d < 3'd2);
    end
  end

  assign load_edge_o = (phase_d == 3'(LOAD_PHASE));
  assign pclk_o      = pclk_q;

endmodule

// File: rtl/oser10_tx_ctrl.sv
// Bring-up sequencer and slot scheduler for one OSER10 + TLVDS_TBUF lane:
// holds the serializer in reset, warms it up, streams words, drains on disable.
module oser10_tx_ctrl
  import oser10_pkg::*;
#(
  parameter logic [WORD_W-1:0] IDLE_WORD    = IDLE_WORD_DEF,
  parameter int unsigned       RST_SLOTS    = 2,
  parameter int unsigned       WARMUP_SLOTS = 4,
  parameter int unsigned       DRAIN_SLOTS  = 2,
  parameter int unsigned       LOAD_PHASE   = 3
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  output logic              s_ready,
  output logic              pclk_o,
  output logic              oser_rst_o,
  output logic [WORD_W-1:0] d_o,
  output logic              oen_o,
  output logic              underrun_o
);

  localparam int unsigned CNT_W = cnt_width(RST_SLOTS, WARMUP_SLOTS, DRAIN_SLOTS);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   data_buf_q, data_buf_d;
  logic                buf_full_q, buf_full_d;
  logic [WORD_W-1:0]   d_q, d_d;
  logic                oser_rst_q, oser_rst_d;
  logic                oen_q, oen_d;
  logic                underrun_q, underrun_d;
  logic                load_edge;
  logic                accept;
  logic                consume;

  oser10_pclk_div #(
    .LOAD_PHASE(LOAD_PHASE)
  ) u_pclk_div (
    .clk        (clk),
    .rst_i      (rst_i),
    .pclk_o     (pclk_o),
    .load_edge_o(load_edge)
  );

  assign s_ready = (state_q == ST_RUN) & ~buf_full_q;
  assign accept  = s_valid & s_ready;
  assign consume = load_edge & buf_full_q &
                   ((state_q == ST_RUN) | (state_q == ST_DRAIN));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    d_d        = d_q;
    oser_rst_d = oser_rst_q;
    oen_d      = oen_q;
    underrun_d = 1'b0;
    data_buf_d = data_buf_q;
    buf_full_d = buf_full_q;

    if (load_edge) begin
      d_d        = consume ? data_buf_q : IDLE_WORD;
      underrun_d = (state_q == ST_RUN) & ~buf_full_q;

      unique case (state_q)
        ST_HOLD: begin
          if (cnt_q == '0) begin
            state_d = ST_WARMUP;
            cnt_d   = CNT_W'(WARMUP_SLOTS - 1);
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_WARMUP: begin
          if (cnt_q == '0) begin
            state_d = en_i ? ST_RUN : ST_OFF;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_RUN: begin
          if (!en_i) begin
            state_d = ST_DRAIN;
            cnt_d   = CNT_W'(DRAIN_SLOTS);
          end
        end
        // A word accepted on the RUN->DRAIN edge is still pending here;
        // idle slots are only counted once it has gone out.
        ST_DRAIN: begin
          if (!buf_full_q) begin
            if (cnt_q == '0) begin
              state_d = ST_OFF;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        ST_OFF: begin
          if (en_i) begin
            state_d = ST_WARMUP;
            cnt_d   = CNT_W'(WARMUP_SLOTS - 1);
          end
        end
        default: state_d = ST_HOLD;
      endcase

      oser_rst_d = (state_d == ST_HOLD);
      oen_d      = (state_d == ST_HOLD) | (state_d == ST_OFF);
    end

    // Consumption sees the old buffer; a same-edge accept refills it.
    if (consume) buf_full_d = 1'b0;
    if (accept) begin
      data_buf_d = s_data;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_HOLD;
      cnt_q      <= CNT_W'(RST_SLOTS - 1);
      d_q        <= IDLE_WORD;
      oser_rst_q <= 1'b1;
      oen_q      <= 1'b1;
      underrun_q <= 1'b0;
      data_buf_q <= '0;
      buf_full_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      d_q        <= d_d;
      oser_rst_q <= oser_rst_d;
      oen_q      <= oen_d;
      underrun_q <= underrun_d;
      data_buf_q <= data_buf_d;
      buf_full_q <= buf_full_d;
    end
  end

  assign d_o        = d_q;
  assign oser_rst_o = oser_rst_q;
  assign oen_o      = oen_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_oser10_tx_ctrl.sv
// Self-checking bench for oser10_tx_ctrl against a slot-level reference model.
module tb_oser10_tx_ctrl;

  localparam logic [9:0] IDLE   = 10'h2AA;
  localparam int         RST_N  = 2;
  localparam int         WARM_N = 4;
  localparam int         DRN_N  = 2;
  localparam int         LOADP  = 3;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       en_i = 1'b0;
  logic       s_valid = 1'b0;
  logic [9:0] s_data = '0;
  logic       s_ready;
  logic       pclk_o;
  logic       oser_rst_o;
  logic [9:0] d_o;
  logic       oen_o;
  logic       underrun_o;

  oser10_tx_ctrl #(
    .IDLE_WORD   (IDLE),
    .RST_SLOTS   (RST_N),
    .WARMUP_SLOTS(WARM_N),
    .DRAIN_SLOTS (DRN_N),
    .LOAD_PHASE  (LOADP)
  ) dut (
    .clk       (clk),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .pclk_o    (pclk_o),
    .oser_rst_o(oser_rst_o),
    .d_o       (d_o),
    .oen_o     (oen_o),
    .underrun_o(underrun_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks the lane by slots, with the pending word in a queue.
  typedef enum int {M_HOLD, M_WARM, M_RUN, M_DRAIN, M_OFF} mmode_e;
  mmode_e     m_mode;
  int         m_ph;
  int         m_slots;
  logic [9:0] m_q[$];
  logic [9:0] m_d;
  bit         m_und;
  bit         m_accept;

  function automatic void model_reset();
    m_mode   = M_HOLD;
    m_ph     = 4;
    m_slots  = 0;
    m_q.delete();
    m_d      = IDLE;
    m_und    = 0;
    m_accept = 0;
  endfunction

  function automatic bit model_ready();
    return (m_mode == M_RUN) && (m_q.size() == 0);
  endfunction

  function automatic void model_edge(input bit en, input bit v, input logic [9:0] data);
    bit acc;
    bit emitted;
    acc     = v && model_ready();
    emitted = 0;
    m_ph    = (m_ph + 1) % 5;
    m_und   = 0;
    if (m_ph == LOADP) begin
      if ((m_mode == M_RUN || m_mode == M_DRAIN) && m_q.size() > 0) begin
        m_d = m_q.pop_front();
        emitted = 1;
      end else begin
        m_d   = IDLE;
        m_und = (m_mode == M_RUN);
      end
      case (m_mode)
        M_HOLD: begin
          m_slots++;
          if (m_slots == RST_N) begin m_mode = M_WARM; m_slots = 0; end
        end
        M_WARM: begin
          m_slots++;
          if (m_slots == WARM_N) begin m_mode = en ? M_RUN : M_OFF; m_slots = 0; end
        end
        M_RUN: if (!en) begin m_mode = M_DRAIN; m_slots = 0; end
        M_DRAIN: if (!emitted) begin
          m_slots++;
          if (m_slots > DRN_N) begin m_mode = M_OFF; m_slots = 0; end
        end
        M_OFF: if (en) begin m_mode = M_WARM; m_slots = 0; end
        default: ;
      endcase
    end
    if (acc) m_q.push_back(data);
    m_accept = acc;
  endfunction

  task automatic compare_all();
    check("pclk",     pclk_o,     (m_ph < 2));
    check("d",        d_o,        m_d);
    check("oen",      oen_o,      (m_mode == M_HOLD || m_mode == M_OFF));
    check("oser_rst", oser_rst_o, (m_mode == M_HOLD));
    check("underrun", underrun_o, m_und);
    check("s_ready",  s_ready,    model_ready());
  endtask

  // Called at a falling edge: drive, step the model at the rising edge, check, return at the next falling edge.
  task automatic cycle(input bit en, input bit v, input logic [9:0] data);
    en_i = en; s_valid = v; s_data = data;
    @(posedge clk);
    model_edge(en, v, data);
    #1 compare_all();
    @(negedge clk);
  endtask

  task automatic timeout(input string tag);
    n_tests++;
    n_fail++;
    $display("FAIL timeout %s got=not-reached exp=reached at %0t", tag, $time);
  endtask

  task automatic run_until_mode(input mmode_e target, input bit en, input string tag);
    for (int k = 0; k < 200 && m_mode != target; k++) cycle(en, 1'b0, '0);
    if (m_mode != target) timeout(tag);
  endtask

  task automatic send(input logic [9:0] w, input string tag);
    bit done;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      cycle(1'b1, 1'b1, w);
      done = m_accept;
    end
    if (!done) timeout(tag);
  endtask

  logic [9:0] words [3];
  bit         en_r;
  int         pct;

  initial begin
    words[0] = 10'h001; words[1] = 10'h3FE; words[2] = 10'h155;
    #2 rst_i = 1'b1;
    model_reset();
    #1 compare_all();
    repeat (2) begin @(posedge clk); #1 compare_all(); end
    @(negedge clk);
    rst_i = 1'b0;

    // Bring-up with enable high, then a stalled stream.
    run_until_mode(M_RUN, 1'b1, "bringup");
    for (int k = 0; k < 15; k++) cycle(1'b1, 1'b0, '0);

    // Back-to-back words held valid.
    for (int i = 0; i < 3; i++) send(words[i], "b2b");
    for (int k = 0; k < 12; k++) cycle(1'b1, 1'b0, '0);

    // Buffer full with 0F0 while a new word waits.
    send(10'h0F0, "buf0f0");
    send(10'h2C3, "bufnext");
    for (int k = 0; k < 12; k++) cycle(1'b1, 1'b0, '0);

    // Disable with a word buffered just after a load edge.
    for (int k = 0; k < 10 && m_ph != LOADP; k++) cycle(1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 10'h123);
    run_until_mode(M_OFF, 1'b0, "drain");
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, '0);
    run_until_mode(M_RUN, 1'b1, "reenable");

    // Randomized traffic with slow and per-cycle enable changes.
    en_r = 1;
    for (int blk = 0; blk < 15; blk++) begin
      pct = $urandom_range(20, 100);
      for (int k = 0; k < 200; k++) begin
        if (blk % 5 == 4) en_r = $urandom_range(0, 1) != 0;
        else if ($urandom_range(0, 59) == 0) en_r = ~en_r;
        cycle(en_r, $urandom_range(0, 99) < pct, 10'($urandom));
      end
    end

    // Asynchronous reset between edges while streaming.
    run_until_mode(M_RUN, 1'b1, "prereset");
    send(10'h0AB, "prereset_w0");
    send(10'h354, "prereset_w1");
    cycle(1'b1, 1'b1, 10'h0CD);
    rst_i = 1'b1;
    model_reset();
    #1 compare_all();
    repeat (2) begin @(posedge clk); #1 compare_all(); end
    @(negedge clk);
    rst_i = 1'b0;
    run_until_mode(M_RUN, 1'b1, "postreset");
    send(10'h3C0, "postreset_w");
    for (int k = 0; k < 12; k++) cycle(1'b1, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
